riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit between the multi-cycle control unit and the word-wide data RAM. It accepts one load or store per request strobe and generates word-aligned RAM accesses with byte enables, splitting misaligned accesses into two word transactions. Load data is aligned and sign/zero-extended per RV32I `funct3` before the control unit writes it back. Busy/done status lets the controller stall its fetch/execute sequencing on memory latency.

## Interface
- `ADDR_W`, 32: byte-address width; RAM word address is `{addr[ADDR_W-1:2],2'b00}`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_RE` in 1: load request, sampled in IDLE.
- `mem_WE` in 1: store request, sampled in IDLE.
- `funct3` in 3: access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores accept only 000/001/010.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, right-justified.
- `rdata` out 32: extended load result, valid with `done`, held until the next load completes.
- `busy` out 1: high from acceptance until the DONE cycle, inclusive.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse for an illegal request; no RAM access is made.
- `misalign` out 1: high with `done` if the access was split.
- `ram_req` out 1: RAM request, held until ack.
- `ram_we` out 1: RAM write.
- `ram_addr` out ADDR_W: word-aligned address.
- `ram_be` out 4: byte lane enables; bit i selects byte lane i (bits 8i+7:8i).
- `ram_wdata` out 32: lane-positioned write data.
- `ram_rdata` in 32: read word, valid when `ram_ack`=1.
- `ram_ack` in 1: transaction complete at this edge.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE: on an edge with `mem_RE`^`mem_WE`=1 and a legal `funct3`, the unit captures `addr`, `funct3`, `wdata`, and direction, then goes to ACC0.
  - Both strobes high, or illegal `funct3`: the unit pulses `err` for the next cycle and stays in IDLE.
  - Strobes while not in IDLE are ignored and not queued.
- Offset is `off=addr[1:0]`. The access is split when `off+size>4` (size 1, 2, or 4 bytes).
- ACC0: drives word0 = aligned `addr`.
  - `ram_be` = (size mask << off) & 4'hF.
  - `ram_wdata` = `wdata` << 8·off.
  - On ack: go to ACC1 if split, else DONE. Load data is captured into a low holding register.
- ACC1: drives word1 = word0+4, wrapping modulo 2^ADDR_W.
  - `ram_be` = size mask >> (4−off).
  - `ram_wdata` = `wdata` >> 8·(4−off).
  - On ack: go to DONE. Load data is captured into a high holding register.
- DONE: `done`=1 for one cycle; `rdata` is registered on the entry edge. Next state is IDLE.
- Load result: the low 32 bits of ({high,low} >> 8·off) are truncated to size, then sign-extended for B/H or zero-extended for BU/HU/W.
- `ram_req`, `ram_addr`, `ram_be`, `ram_wdata`, and `ram_we` are registered and stable while `ram_req`=1. `ram_req` is 0 in IDLE and DONE, and on the edge where ack is taken.
- Reset (asynchronous, including mid-transaction): state returns to IDLE. All outputs reset to 0, including `rdata`, `ram_addr`, `ram_be`, `ram_wdata`, and holding registers. An ack arriving after reset is ignored.

## Timing
- Acceptance edge T: ACC0 and `ram_req`=1 from T.
- Aligned access, ack at first opportunity (edge T+1): `done` is high during cycle T+1→T+2. `busy` is high in cycles T through T+2.
- Split access adds one cycle plus RAM wait cycles.
- Each RAM wait cycle (ack=0) extends latency by exactly one cycle.
- `ram_req` never drops without an ack, except by reset.
- Back-to-back: a new request is accepted on the first edge in IDLE after DONE.

## Test plan
- LW, addr 0x100, RAM returns 0x87654321 with immediate ack: one access at 0x100 with `be`=1111; `done` 2 cycles after acceptance; `rdata`=0x87654321, `misalign`=0.
- LB and LBU, addr 0x103, word 0x80112233: `be`=1000 for both. LB gives `rdata`=0xFFFFFF80; LBU gives 0x00000080.
- SH, addr 0x103, `wdata`=0x0000BEEF: first access at 0x100 with `be`=1000 and `ram_wdata`=0xEF000000; second at 0x104 with `be`=0001 and `ram_wdata`=0x000000BE. `misalign`=1 with `done`.
- LW, addr 0x1FE, with 0x1FC=0xAABBCCDD and 0x200=0x11223344: accesses at 0x1FC (`be`=1100) then 0x200 (`be`=0011); `rdata`=0x3344AABB.
- SW, addr 0xFFFFFFFF: second access at 0x00000000. With ack delayed 3 cycles, `ram_req`, `addr`, `be`, and `wdata` stay stable throughout.
- Illegal requests and reset:
  - Load with `funct3`=011: `err` pulse, no `ram_req`.
  - `mem_RE`=`mem_WE`=1: `err` pulse.
  - `rst_n` low during ACC1 wait: all outputs 0 immediately; the next request proceeds normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: turns one RV32I load/store into one or two word-aligned RAM
// transactions with byte enables, and aligns/extends load data for write-back.
module riscv_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_RE,
  input  logic              mem_WE,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              misalign,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       hold_lo_q, hold_lo_d;
  logic [31:0]       hold_hi_q, hold_hi_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              split_q, split_d;

  logic              f3_legal;
  logic              req_ok;
  logic              req_bad;
  logic [1:0]        off_src;
  logic [1:0]        sz_src;
  logic [31:0]       wdata_src;
  logic [7:0]        be_sh;
  logic [63:0]       wd_sh;
  logic              split_src;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_result(input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] w;
    w = 32'({hi, lo} >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h000000, w[7:0]};
      3'b101:  return {16'h0000, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Request legality: stores only take B/H/W, loads also take BU/HU.
  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = mem_RE;
      default:                f3_legal = 1'b0;
    endcase
    req_ok  = (mem_RE ^ mem_WE) && f3_legal;
    req_bad = (mem_RE | mem_WE) && !req_ok;
  end

  // One lane shifter serves both words: low half is word0, high half is word1.
  always_comb begin
    if (state_q == S_IDLE) begin
      off_src   = addr[1:0];
      sz_src    = funct3[1:0];
      wdata_src = wdata;
    end else begin
      off_src   = off_q;
      sz_src    = f3_q[1:0];
      wdata_src = wdata_q;
    end
    be_sh     = {4'b0000, size_mask(sz_src)} << off_src;
    wd_sh     = {32'h0000_0000, wdata_src} << {off_src, 3'b000};
    split_src = ({1'b0, off_src} + size_bytes(sz_src)) > 3'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= 4'h0;
      ram_wdata_q <= 32'h0;
      hold_lo_q   <= 32'h0;
      hold_hi_q   <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      wdata_q     <= 32'h0;
      split_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_be_q    <= ram_be_d;
      ram_wdata_q <= ram_wdata_d;
      hold_lo_q   <= hold_lo_d;
      hold_hi_q   <= hold_hi_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      split_q     <= split_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_ok) state_d = S_ACC0;
      S_ACC0: if (ram_ack) state_d = split_q ? S_ACC1 : S_DONE;
      S_ACC1: if (ram_ack) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_be_d    = ram_be_q;
    ram_wdata_d = ram_wdata_q;
    hold_lo_d   = hold_lo_q;
    hold_hi_d   = hold_hi_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    off_d       = off_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    split_d     = split_q;
    case (state_q)
      S_IDLE: begin
        err_d = req_bad;
        if (req_ok) begin
          off_d       = addr[1:0];
          f3_d        = funct3;
          wdata_d     = wdata;
          split_d     = split_src;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_WE;
          ram_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          ram_be_d    = be_sh[3:0];
          ram_wdata_d = wd_sh[31:0];
        end
      end
      S_ACC0: begin
        if (ram_ack) begin
          hold_lo_d = ram_rdata;
          if (split_q) begin
            // Second word wraps naturally at the top of the address space.
            ram_addr_d  = ram_addr_q + ADDR_W'(4);
            ram_be_d    = be_sh[7:4];
            ram_wdata_d = wd_sh[63:32];
          end else begin
            ram_req_d = 1'b0;
            if (!ram_we_q) rdata_d = load_result(hold_hi_q, ram_rdata, off_q, f3_q);
          end
        end
      end
      S_ACC1: begin
        if (ram_ack) begin
          hold_hi_d = ram_rdata;
          ram_req_d = 1'b0;
          if (!ram_we_q) rdata_d = load_result(ram_rdata, hold_lo_q, off_q, f3_q);
        end
      end
      default: ;
    endcase
  end

  assign rdata     = rdata_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign misalign  = done && split_q;
  assign err       = err_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_be    = ram_be_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: byte-level memory model, RAM responder with wait states,
// directed cases and randomized loads/stores.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_RE, mem_WE;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, err, misalign;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  riscv_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_RE(mem_RE), .mem_WE(mem_WE), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .misalign(misalign), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } acc_t;

  int          errors = 0;
  int          checks = 0;
  int          wait_target = 0;
  acc_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mdl_rdata = 32'h0;
  logic        obs_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0] ^ 16'hA5C3, ~wa[15:0]};
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] ba);
    logic [31:0] w;
    w = rd_word({ba[31:2], 2'b00});
    return w[8*ba[1:0] +: 8];
  endfunction

  function automatic acc_t acc_at(input int i);
    acc_t e;
    e = '{a: 32'h0, be: 4'h0, wd: 32'h0, we: 1'b0};
    if (i < log_q.size()) e = log_q[i];
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // RAM responder: acks after wait_target idle cycles, checks request stability.
  initial begin : ram_model
    int cnt;
    bit pend;
    acc_t snap;
    logic [31:0] w;
    cnt = 0; pend = 0;
    ram_ack = 1'b0; ram_rdata = 32'h0;
    snap = '{a: 32'h0, be: 4'h0, wd: 32'h0, we: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ram_ack = 1'b0; cnt = 0; pend = 0;
      end else begin
        if (pend) chk("req_held_until_ack", {31'h0, ram_req}, 32'h1);
        if (!ram_req) begin
          ram_ack = 1'b0; ram_rdata = 32'hDEAD_BEEF; cnt = 0; pend = 0;
        end else begin
          if (cnt == 0) begin
            snap = '{a: ram_addr, be: ram_be, wd: ram_wdata, we: ram_we};
          end else begin
            chk("stable_addr", ram_addr, snap.a);
            chk("stable_be", {28'h0, ram_be}, {28'h0, snap.be});
            chk("stable_wdata", ram_wdata, snap.wd);
          end
          if (cnt >= wait_target) begin
            ram_ack = 1'b1;
            ram_rdata = rd_word(ram_addr);
            if (ram_we) begin
              w = rd_word(ram_addr);
              for (int l = 0; l < 4; l++) if (ram_be[l]) w[8*l +: 8] = ram_wdata[8*l +: 8];
              mem[ram_addr] = w;
            end
            log_q.push_back('{a: ram_addr, be: ram_be, wd: ram_wdata, we: ram_we});
            cnt = 0; pend = 0;
          end else begin
            ram_ack = 1'b0; ram_rdata = 32'hDEAD_BEEF; cnt++; pend = 1;
          end
        end
      end
    end
  end

  // One request; expectations come from a per-byte view of the access.
  task automatic do_op(input bit re, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int w);
    int          sz, n, exp_n, k;
    logic [31:0] wa[2];
    logic [3:0]  ebe[2];
    logic [31:0] ewd[2];
    logic [31:0] val, ba;
    bit          split;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    wa[0] = {a[31:2], 2'b00};
    wa[1] = wa[0];
    ebe[0] = 4'h0; ebe[1] = 4'h0; ewd[0] = 32'h0; ewd[1] = 32'h0; val = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      k = ({ba[31:2], 2'b00} == wa[0]) ? 0 : 1;
      if (k == 1) wa[1] = {ba[31:2], 2'b00};
      ebe[k][ba[1:0]] = 1'b1;
      ewd[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
      val[8*i +: 8] = byte_at(ba);
    end
    if (!f3[2] && sz < 4)
      for (int i = sz; i < 4; i++) val[8*i +: 8] = {8{val[8*sz-1]}};
    split = (ebe[1] != 4'h0);
    if (re) mdl_rdata = val;
    exp_n = 2 + w + (split ? 1 + w : 0);

    wait_target = w;
    log_q.delete();
    @(negedge clk);
    mem_RE = re; mem_WE = we; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    mem_RE = 1'b0; mem_WE = 1'b0; addr = $urandom; wdata = $urandom;
    n = 1;
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, exp_n);
    obs_mis = misalign;
    chk("misalign", {31'h0, misalign}, {31'h0, split});
    chk("rdata", rdata, mdl_rdata);
    chk("busy_in_done", {31'h0, busy}, 32'h1);
    chk("access_count", log_q.size(), split ? 2 : 1);
    for (int j = 0; j < (split ? 2 : 1); j++) begin
      chk("acc_addr", acc_at(j).a, wa[j]);
      chk("acc_be", {28'h0, acc_at(j).be}, {28'h0, ebe[j]});
      chk("acc_we", {31'h0, acc_at(j).we}, {31'h0, we});
      if (we) chk("acc_wdata", acc_at(j).wd & lane_mask(ebe[j]), ewd[j]);
    end
    @(negedge clk);
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("idle_not_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic do_err(input bit re, input bit we, input logic [2:0] f3);
    log_q.delete();
    @(negedge clk);
    mem_RE = re; mem_WE = we; funct3 = f3; addr = $urandom; wdata = $urandom;
    @(negedge clk);
    mem_RE = 1'b0; mem_WE = 1'b0;
    chk("err_pulse", {31'h0, err}, 32'h1);
    chk("err_no_req", {31'h0, ram_req}, 32'h0);
    chk("err_not_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("err_single_cycle", {31'h0, err}, 32'h0);
    chk("err_no_access", log_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_ctl"}, {24'h0, ram_be, ram_req, ram_we, busy, done},
        32'h0);
    chk({tag, "_status"}, {30'h0, err, misalign}, 32'h0);
  endtask

  initial begin : stim
    int t;
    rst_n = 1'b0;
    mem_RE = 1'b0; mem_WE = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    mem[32'h100] = 32'h8765_4321;
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 0);
    chk("lw_rdata", rdata, 32'h8765_4321);
    chk("lw_be", {28'h0, acc_at(0).be}, 32'hF);

    mem[32'h100] = 32'h8011_2233;
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_be", {28'h0, acc_at(0).be}, 32'h8);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 1);
    chk("lbu_rdata", rdata, 32'h0000_0080);

    do_op(0, 1, 3'b001, 32'h103, 32'h0000_BEEF, 1);
    chk("sh_a0", acc_at(0).a, 32'h100);
    chk("sh_wd0", acc_at(0).wd, 32'hEF00_0000);
    chk("sh_a1", acc_at(1).a, 32'h104);
    chk("sh_wd1", acc_at(1).wd, 32'h0000_00BE);
    chk("sh_misalign", {31'h0, obs_mis}, 32'h1);
    chk("sh_rdata_held", rdata, 32'h0000_0080);

    mem[32'h1FC] = 32'hAABB_CCDD;
    mem[32'h200] = 32'h1122_3344;
    do_op(1, 0, 3'b010, 32'h1FE, 32'h0, 0);
    chk("lw_split_rdata", rdata, 32'h3344_AABB);
    chk("lw_split_be0", {28'h0, acc_at(0).be}, 32'hC);
    chk("lw_split_be1", {28'h0, acc_at(1).be}, 32'h3);

    do_op(0, 1, 3'b010, 32'hFFFF_FFFF, 32'h1234_5678, 3);
    chk("sw_wrap_a1", acc_at(1).a, 32'h0);

    do_err(1, 0, 3'b011);
    do_err(0, 1, 3'b100);
    do_err(1, 1, 3'b010);

    // Reset while the second word of a split store is waiting for ack.
    wait_target = 8;
    log_q.delete();
    @(negedge clk);
    mem_WE = 1'b1; funct3 = 3'b010; addr = 32'h402; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_WE = 1'b0;
    t = 0;
    while (log_q.size() < 1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rst_first_word_acked", log_q.size(), 1);
    repeat (2) @(negedge clk);
    chk("rst_in_acc1", {31'h0, ram_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    mdl_rdata = 32'h0;
    do_op(1, 0, 3'b001, 32'h402, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      bit          isw;
      int          r;
      logic [2:0]  f3;
      logic [31:0] a;
      isw = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 4);
      f3 = isw ? 3'(r % 3) : (r < 3 ? 3'(r) : 3'(r + 1));
      a = (i % 10 == 9) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                        : (32'h300 + 32'($urandom_range(0, 15)));
      do_op(!isw, isw, f3, a, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
